// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default geometry,
// FSM state encoding and byte-lane packing helper.
package imem_loader_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Little-endian placement: lane 0 -> [7:0], lane 3 -> [31:24].
  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_assembler.sv
// 8->32 packing register with 2-bit byte counter, clear input and a
// word_full flag that marks the beat completing the current word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  // word_next already includes the byte of the current beat, so the full
  // word is available in the same cycle as the 4th transfer.
  always_comb begin
    word_next = merge_byte(word_q, cnt_q, byte_in);
    word_full = byte_en && (cnt_q == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (byte_en) begin
      word_q <= word_next;
      cnt_q  <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: packs a byte stream into words,
// writes them to consecutive addresses and holds the CPU for the whole load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load_Start,
  input  logic [ADDR_W:0]   Load_Len,
  input  logic [7:0]        Byte_In,
  input  logic              Byte_Valid,
  output logic              Byte_Ready,
  output logic              Mem_WrEn,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_WrData,
  output logic              Cpu_Hold,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              err_q;
  logic              len_ok, last_word, beat, asm_clear, word_full;
  logic [31:0]       word_next;

  assign len_ok     = (Load_Len != '0) && (Load_Len <= MAX_LEN);
  assign last_word  = ({1'b0, idx_q} == (len_q - 1'b1));
  assign beat       = Byte_Valid && Byte_Ready;
  assign Mem_Addr   = addr_q;
  assign Mem_WrData = data_q;
  assign Err        = err_q;

  word_assembler u_asm (
    .clk       (Clk),
    .rst       (Reset),
    .clear     (asm_clear),
    .byte_en   (beat),
    .byte_in   (Byte_In),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_comb begin
    state_d    = state_q;
    Byte_Ready = 1'b0;
    Cpu_Hold   = 1'b0;
    Busy       = 1'b0;
    Mem_WrEn   = 1'b0;
    Done       = 1'b0;
    asm_clear  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Load_Start && len_ok) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        Byte_Ready = 1'b1;
        Cpu_Hold   = 1'b1;
        Busy       = 1'b1;
        if (word_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        Cpu_Hold  = 1'b1;
        Busy      = 1'b1;
        Mem_WrEn  = 1'b1;
        asm_clear = 1'b1;
        state_d   = last_word ? ST_RELEASE : ST_COLLECT;
      end
      ST_RELEASE: begin
        Cpu_Hold = 1'b1;
        Busy     = 1'b1;
        Done     = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/data are captured on the completing beat so they hold their
  // values after WRITE even though the index advances.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && Load_Start) begin
        if (len_ok) begin
          len_q <= Load_Len;
          idx_q <= '0;
          err_q <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (state_q == ST_COLLECT && word_full) begin
        addr_q <= idx_q;
        data_q <= word_next;
      end
      if (state_q == ST_WRITE && !last_word) idx_q <= idx_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a write-capturing memory model.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Load_Start = 1'b0;
  logic [ADDR_W:0]   Load_Len = '0;
  logic [7:0]        Byte_In = '0;
  logic              Byte_Valid = 1'b0;
  logic              Byte_Ready, Mem_WrEn, Cpu_Hold, Busy, Done, Err;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [31:0]       Mem_WrData;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];
  int wr_count, done_count, addr0_writes, rdy_in_wr, hold_drop, seq_err, exp_addr, last_addr;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Load_Start (Load_Start),
    .Load_Len   (Load_Len),
    .Byte_In    (Byte_In),
    .Byte_Valid (Byte_Valid),
    .Byte_Ready (Byte_Ready),
    .Mem_WrEn   (Mem_WrEn),
    .Mem_Addr   (Mem_Addr),
    .Mem_WrData (Mem_WrData),
    .Cpu_Hold   (Cpu_Hold),
    .Busy       (Busy),
    .Done       (Done),
    .Err        (Err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Mem_WrEn) begin
      mem[Mem_Addr] = Mem_WrData;
      wr_count++;
      if (int'(Mem_Addr) != exp_addr) seq_err++;
      exp_addr = int'(Mem_Addr) + 1;
      if (Mem_Addr == '0) addr0_writes++;
      last_addr = int'(Mem_Addr);
      if (Byte_Ready) rdy_in_wr++;
    end
    if (Done) begin
      done_count++;
      if (!Cpu_Hold) hold_drop++;
    end
  end

  task automatic clear_model();
    wr_count = 0; done_count = 0; addr0_writes = 0; rdy_in_wr = 0;
    hold_drop = 0; seq_err = 0; exp_addr = 0; last_addr = -1;
  endtask

  task automatic start_load(input int len);
    Load_Start = 1'b1;
    Load_Len   = (ADDR_W+1)'(len);
    @(posedge Clk); #1;
    Load_Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 0;
    if (gap) begin
      Byte_Valid = 1'b0;
      @(posedge Clk); #1;
    end
    Byte_Valid = 1'b1;
    Byte_In    = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (Byte_Ready) begin
        @(posedge Clk); #1;
        ok = 1;
        break;
      end
    end
    Byte_Valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL byte_accept_timeout: byte %h never accepted, required acceptance within 50 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], gap);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (!Busy) begin ok = 1; break; end
    end
    #1;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: Busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({Byte_Ready, Mem_WrEn, Cpu_Hold, Busy, Done, Err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000", {Byte_Ready, Mem_WrEn, Cpu_Hold, Busy, Done, Err});
    end
    checks++;
    if (Mem_Addr !== '0 || Mem_WrData !== '0) begin
      errors++;
      $display("FAIL reset_mem_bus: addr=%0d data=%h required 0/0", Mem_Addr, Mem_WrData);
    end
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic_load();
    clear_model();
    Byte_Valid = 1'b1;
    Byte_In    = 8'h99;
    Load_Start = 1'b1;
    Load_Len   = 11'd2;
    @(negedge Clk);
    checks++;
    if (Byte_Ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: Byte_Ready=%b with Load_Start in IDLE, required 0", Byte_Ready);
    end
    @(posedge Clk); #1;
    Load_Start = 1'b0;
    Byte_Valid = 1'b0;
    @(negedge Clk);
    checks++;
    if (Byte_Ready !== 1'b1 || Cpu_Hold !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: ready=%b hold=%b one cycle after start, required 1/1", Byte_Ready, Cpu_Hold);
    end
    @(posedge Clk); #1;
    send_word(32'h12345678, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    wait_idle(20);
    checks++;
    if (wr_count !== 2 || seq_err !== 0) begin
      errors++;
      $display("FAIL basic_writes: count=%0d seq_err=%0d required 2/0", wr_count, seq_err);
    end
    checks++;
    if (mem[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_word0: got %h required 12345678", mem[0]);
    end
    checks++;
    if (mem[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_word1: got %h required deadbeef", mem[1]);
    end
    checks++;
    if (done_count !== 1 || hold_drop !== 0) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d hold_low_at_done=%0d required 1/0", done_count, hold_drop);
    end
    checks++;
    if (Cpu_Hold !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: hold=%b done=%b required 0/0", Cpu_Hold, Done);
    end
    checks++;
    if (Mem_Addr !== 10'd1 || Mem_WrData !== 32'hDEADBEEF || Mem_WrEn !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold_bus: addr=%0d data=%h wren=%b required 1/deadbeef/0", Mem_Addr, Mem_WrData, Mem_WrEn);
    end
  endtask

  task automatic test_stall_load();
    clear_model();
    start_load(2);
    send_word(32'h12345678, 1'b1);
    send_word(32'hDEADBEEF, 1'b1);
    wait_idle(20);
    checks++;
    if (wr_count !== 2 || mem[0] !== 32'h12345678 || mem[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL stall_writes: count=%0d w0=%h w1=%h required 2/12345678/deadbeef", wr_count, mem[0], mem[1]);
    end
    checks++;
    if (rdy_in_wr !== 0 || done_count !== 1) begin
      errors++;
      $display("FAIL stall_ready_in_write: ready_in_write=%0d done=%0d required 0/1", rdy_in_wr, done_count);
    end
  endtask

  task automatic test_bad_len();
    clear_model();
    start_load(0);
    @(negedge Clk);
    checks++;
    if (Err !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_err: err=%b busy=%b required 1/0", Err, Busy);
    end
    @(posedge Clk); #1;
    start_load(1025);
    @(negedge Clk);
    checks++;
    if (Err !== 1'b1 || Busy !== 1'b0 || Byte_Ready !== 1'b0) begin
      errors++;
      $display("FAIL len1025_err: err=%b busy=%b ready=%b required 1/0/0", Err, Busy, Byte_Ready);
    end
    checks++;
    if (wr_count !== 0) begin
      errors++;
      $display("FAIL bad_len_nowrite: writes=%0d required 0", wr_count);
    end
    @(posedge Clk); #1;
    start_load(1);
    @(negedge Clk);
    checks++;
    if (Err !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL err_clear: err=%b busy=%b required 0/1", Err, Busy);
    end
    @(posedge Clk); #1;
    send_word(32'hCAFEF00D, 1'b0);
    wait_idle(20);
    checks++;
    if (wr_count !== 1 || mem[0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL len1_write: count=%0d w0=%h required 1/cafef00d", wr_count, mem[0]);
    end
  endtask

  task automatic test_reset_mid();
    clear_model();
    start_load(3);
    send_word(32'h04030201, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (Cpu_Hold !== 1'b0 || Busy !== 1'b0 || Mem_WrEn !== 1'b0 || Byte_Ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: hold=%b busy=%b wren=%b ready=%b required 0/0/0/0", Cpu_Hold, Busy, Mem_WrEn, Byte_Ready);
    end
    #1 Reset = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    checks++;
    if (wr_count !== 1 || mem[0] !== 32'h04030201) begin
      errors++;
      $display("FAIL midreset_mem: count=%0d w0=%h required 1/04030201", wr_count, mem[0]);
    end
    start_load(1);
    send_word(32'hDDCCBBAA, 1'b0);
    wait_idle(20);
    checks++;
    if (wr_count !== 2 || mem[0] !== 32'hDDCCBBAA || done_count !== 1) begin
      errors++;
      $display("FAIL midreset_reload: count=%0d w0=%h done=%0d required 2/ddccbbaa/1", wr_count, mem[0], done_count);
    end
  endtask

  task automatic test_full_len();
    clear_model();
    start_load(1024);
    for (int w = 0; w < 1024; w++) send_word(32'hC0DE0000 | 32'(w), 1'b0);
    wait_idle(20);
    checks++;
    if (wr_count !== 1024 || seq_err !== 0 || last_addr !== 1023) begin
      errors++;
      $display("FAIL full_writes: count=%0d seq_err=%0d last_addr=%0d required 1024/0/1023", wr_count, seq_err, last_addr);
    end
    checks++;
    if (addr0_writes !== 1 || done_count !== 1) begin
      errors++;
      $display("FAIL full_no_wrap: addr0_writes=%0d done=%0d required 1/1", addr0_writes, done_count);
    end
    checks++;
    if (mem[0] !== 32'hC0DE0000 || mem[512] !== 32'hC0DE0200 || mem[1023] !== 32'hC0DE03FF) begin
      errors++;
      $display("FAIL full_data: w0=%h w512=%h w1023=%h required c0de0000/c0de0200/c0de03ff", mem[0], mem[512], mem[1023]);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_basic_load();
    test_stall_load();
    test_bad_len();
    test_reset_mid();
    test_full_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
